// File: rtl/ram_port_arbiter.sv
// Arbitrates the shared single-port SPI RAM between the SPI receive stream and a local host port,
// holding the RAM for one requester from an address command until its data command completes.
module ram_port_arbiter #(
  parameter int ADDR_SIZE    = 8,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] spi_rx_data,
  input  logic                 spi_rx_valid,
  output logic [ADDR_SIZE-1:0] spi_tx_data,
  output logic                 spi_tx_valid,
  input  logic [ADDR_SIZE+1:0] host_din,
  input  logic                 host_req,
  output logic                 host_gnt,
  output logic [ADDR_SIZE-1:0] host_dout,
  output logic                 host_dout_valid,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic [1:0]           owner,
  output logic                 spi_overrun,
  output logic                 lock_timeout
);

  localparam int CW = ADDR_SIZE + 2;
  localparam int TW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_SPI  = 2'b01;
  localparam logic [1:0] OWN_HOST = 2'b10;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOCKED  = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [1:0]      owner_n;
  logic            buf_valid;
  logic [CW-1:0]   buf_data;
  logic            rr_host;
  logic [TW-1:0]   tmo_cnt;

  logic            spi_issue, host_issue, issue;
  logic [CW-1:0]   issue_cmd;
  logic [1:0]      issue_op;
  logic            rd_done, tmo_hit;

  // Host handshake: a command transfers in any cycle where host_req and host_gnt are both high;
  // host_gnt is combinational and host_din must stay stable until that cycle.
  always_comb begin
    spi_issue  = 1'b0;
    host_issue = 1'b0;
    case (state)
      S_IDLE: begin
        if (buf_valid && host_req) begin
          host_issue = rr_host;
          spi_issue  = !rr_host;
        end else begin
          spi_issue  = buf_valid;
          host_issue = !buf_valid && host_req;
        end
      end
      S_LOCKED: begin
        spi_issue  = (owner == OWN_SPI) && buf_valid;
        host_issue = (owner == OWN_HOST) && host_req;
      end
      default: ;
    endcase
  end

  assign issue     = spi_issue || host_issue;
  assign issue_cmd = spi_issue ? buf_data : host_din;
  assign issue_op  = issue_cmd[CW-1 -: 2];
  assign host_gnt  = host_issue;
  assign rd_done   = (state == S_WAIT_RD) && ram_tx_valid;
  // A returning read or a fresh issue in the final cycle beats the forced release.
  assign tmo_hit   = (state != S_IDLE) && (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) && !issue && !rd_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    if (issue) begin
      case (issue_op)
        OP_WR_ADDR, OP_RD_ADDR: begin
          state_n = S_LOCKED;
          owner_n = spi_issue ? OWN_SPI : OWN_HOST;
        end
        OP_WR_DATA: begin
          state_n = S_IDLE;
          owner_n = OWN_NONE;
        end
        default: begin
          state_n = S_WAIT_RD;
          owner_n = spi_issue ? OWN_SPI : OWN_HOST;
        end
      endcase
    end else if (rd_done || tmo_hit) begin
      state_n = S_IDLE;
      owner_n = OWN_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid       <= 1'b0;
      buf_data        <= '0;
      spi_overrun     <= 1'b0;
      rr_host         <= 1'b0;
      tmo_cnt         <= '0;
      ram_din         <= '0;
      ram_rx_valid    <= 1'b0;
      spi_tx_data     <= '0;
      spi_tx_valid    <= 1'b0;
      host_dout       <= '0;
      host_dout_valid <= 1'b0;
      lock_timeout    <= 1'b0;
    end else begin
      if (spi_rx_valid && (!buf_valid || spi_issue)) begin
        buf_valid <= 1'b1;
        buf_data  <= spi_rx_data;
      end else if (spi_issue) begin
        buf_valid <= 1'b0;
      end
      spi_overrun <= spi_rx_valid && buf_valid && !spi_issue;

      if (issue && (state == S_IDLE)) begin
        rr_host <= spi_issue;
      end else if (tmo_hit) begin
        rr_host <= (owner == OWN_SPI);
      end

      if (issue || (state_n != state)) begin
        tmo_cnt <= '0;
      end else if (state != S_IDLE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      ram_rx_valid <= issue;
      if (issue) begin
        ram_din <= issue_cmd;
      end

      spi_tx_valid    <= rd_done && (owner == OWN_SPI);
      host_dout_valid <= rd_done && (owner == OWN_HOST);
      if (rd_done && (owner == OWN_SPI)) begin
        spi_tx_data <= ram_dout;
      end
      if (rd_done && (owner == OWN_HOST)) begin
        host_dout <= ram_dout;
      end

      lock_timeout <= tmo_hit;
    end
  end

endmodule
